// File: rtl/qs_pkg.sv
// Shared widths, bank-state types and reset constants for the bank crossbar.
package qs_pkg;

    localparam int BANKS_N = 4;
    localparam int W       = 8;
    localparam int N       = 16;
    localparam int AW      = $clog2(N);
    localparam int BW      = $clog2(BANKS_N);

    typedef enum logic [1:0] {
        BANK_IDLE   = 2'd0,
        BANK_FILL   = 2'd1,
        BANK_SORTED = 2'd2,
        BANK_DRAIN  = 2'd3
    } bank_status_e;

    typedef logic [BW-1:0] bank_id_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [W-1:0]  w_t;

    typedef struct packed {
        bank_status_e  status;
        logic [AW:0]   count;
        addr_t         head;
    } bank_state_t;

    localparam bank_state_t BANK_STATE_RST = '{status: BANK_IDLE, count: '0, head: '0};

endpackage

// File: rtl/qs_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts one past the last winner.
module qs_rr_arb #(
    parameter  int P  = 3,
    localparam int PW = $clog2(P)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [P-1:0] req,
    output logic [P-1:0] gnt
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= P; i++) begin
            idx = (int'(ptr_q) + i) % P;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                ptr_d    = PW'(idx);
                found    = 1'b1;
            end
        end
    end

    // Pointer resets to the last port so port 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PW'(P - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spsram.sv
// Single-port synchronous SRAM, one registered read per cycle, read-before-write.
module spsram #(
    parameter  int W  = 8,
    parameter  int N  = 16,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          wen,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
);

    logic [W-1:0] mem_q [N];
    logic [W-1:0] dout_q;

    // Contents are deliberately not reset; dout always carries the pre-write word.
    always_ff @(posedge clk) begin
        if (en) begin
            dout_q <= mem_q[addr];
            if (wen) begin
                mem_q[addr] <= din;
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/qs_bank_xbar.sv
// P-port to BANKS_N-bank SRAM crossbar with per-bank round-robin arbitration,
// fixed two-cycle read return and a per-bank state register file.
module qs_bank_xbar #(
    parameter  int P       = 3,
    parameter  int BANKS_N = qs_pkg::BANKS_N,
    parameter  int W       = qs_pkg::W,
    parameter  int N       = qs_pkg::N,
    localparam int AW      = $clog2(N),
    localparam int BW      = $clog2(BANKS_N)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [P-1:0][BW-1:0]                st_idx,
    input  logic [P-1:0]                        st_wr,
    input  qs_pkg::bank_state_t [P-1:0]         st_wdata,
    output qs_pkg::bank_state_t [P-1:0]         st_rdata,
    input  logic [P-1:0]                        req,
    input  logic [P-1:0][BW-1:0]                req_bank,
    input  logic [P-1:0]                        req_wen,
    input  logic [P-1:0][AW-1:0]                req_addr,
    input  logic [P-1:0][W-1:0]                 req_wdata,
    output logic [P-1:0]                        gnt,
    output logic [P-1:0]                        rdata_vld,
    output logic [P-1:0][W-1:0]                 rdata
);

    logic [BANKS_N-1:0][P-1:0]  bank_req, bank_gnt;
    logic [BANKS_N-1:0]         sram_en, sram_wen;
    logic [BANKS_N-1:0][AW-1:0] sram_addr;
    logic [BANKS_N-1:0][W-1:0]  sram_din, sram_dout;

    logic [P-1:0]               rd_pend_q, rd_pend_d;
    logic [P-1:0][BW-1:0]       rd_bank_q, rd_bank_d;
    logic [P-1:0]               rdata_vld_q, rdata_vld_d;
    logic [P-1:0][W-1:0]        rdata_q, rdata_d;

    qs_pkg::bank_state_t [BANKS_N-1:0] state_q, state_d;

    // Requests are hidden from the arbiters during reset so no grant escapes.
    always_comb begin
        bank_req = '0;
        for (int p = 0; p < P; p++) begin
            bank_req[req_bank[p]][p] = req[p] & ~rst;
        end
    end

    for (genvar b = 0; b < BANKS_N; b++) begin : g_bank
        qs_rr_arb #(.P(P)) u_arb (
            .clk (clk),
            .rst (rst),
            .req (bank_req[b]),
            .gnt (bank_gnt[b])
        );

        spsram #(.W(W), .N(N)) u_sram (
            .clk  (clk),
            .en   (sram_en[b]),
            .wen  (sram_wen[b]),
            .addr (sram_addr[b]),
            .din  (sram_din[b]),
            .dout (sram_dout[b])
        );
    end

    always_comb begin
        gnt       = '0;
        sram_en   = '0;
        sram_wen  = '0;
        sram_addr = '0;
        sram_din  = '0;
        for (int b = 0; b < BANKS_N; b++) begin
            for (int p = 0; p < P; p++) begin
                if (bank_gnt[b][p]) begin
                    gnt[p]       = 1'b1;
                    sram_en[b]   = 1'b1;
                    sram_wen[b]  = req_wen[p];
                    sram_addr[b] = req_addr[p];
                    sram_din[b]  = req_wdata[p];
                end
            end
        end
    end

    // Stage 1 remembers which bank a read went to; stage 2 captures its dout.
    always_comb begin
        rd_pend_d   = gnt & ~req_wen;
        rd_bank_d   = req_bank;
        rdata_vld_d = rd_pend_q;
        rdata_d     = rdata_q;
        for (int p = 0; p < P; p++) begin
            if (rd_pend_q[p]) begin
                rdata_d[p] = sram_dout[rd_bank_q[p]];
            end
        end
    end

    // Walking from the highest port down lets the lowest writer land last.
    always_comb begin
        state_d = state_q;
        for (int p = P - 1; p >= 0; p--) begin
            if (st_wr[p]) begin
                state_d[st_idx[p]] = st_wdata[p];
            end
        end
    end

    always_comb begin
        st_rdata = '0;
        for (int p = 0; p < P; p++) begin
            st_rdata[p] = state_q[st_idx[p]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q   <= '0;
            rd_bank_q   <= '0;
            rdata_vld_q <= '0;
            rdata_q     <= '0;
            state_q     <= {BANKS_N{qs_pkg::BANK_STATE_RST}};
        end else begin
            rd_pend_q   <= rd_pend_d;
            rd_bank_q   <= rd_bank_d;
            rdata_vld_q <= rdata_vld_d;
            rdata_q     <= rdata_d;
            state_q     <= state_d;
        end
    end

    assign rdata_vld = rdata_vld_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_qs_bank_xbar.sv
// Scoreboard bench for qs_bank_xbar: contention, parallel banks, read latency,
// state-write priority and reset in the middle of a read.
module tb_qs_bank_xbar;
    import qs_pkg::*;

    logic                   clk;
    logic                   rst;
    logic [2:0][1:0]        stIdx;
    logic [2:0]             stWr;
    bank_state_t [2:0]      stWdata;
    bank_state_t [2:0]      stRdata;
    logic [2:0]             req;
    logic [2:0][1:0]        reqBank;
    logic [2:0]             reqWen;
    logic [2:0][3:0]        reqAddr;
    logic [2:0][7:0]        reqWdata;
    logic [2:0]             gnt;
    logic [2:0]             rdataVld;
    logic [2:0][7:0]        rdata;

    typedef struct {
        int         port;
        logic [7:0] data;
        int         cyc;
    } expEntry_t;

    expEntry_t   expQ[$];
    logic [7:0]  modelMem [4][16];
    int          cycleCnt;
    int          passCount;
    int          totalChecks;

    qs_bank_xbar #(.P(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_idx    (stIdx),
        .st_wr     (stWr),
        .st_wdata  (stWdata),
        .st_rdata  (stRdata),
        .req       (req),
        .req_bank  (reqBank),
        .req_wen   (reqWen),
        .req_addr  (reqAddr),
        .req_wdata (reqWdata),
        .gnt       (gnt),
        .rdata_vld (rdataVld),
        .rdata     (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    // One cycle of access stimulus; returns at the following negedge for sampling.
    task automatic applyStimulus(input logic [2:0] r, input logic [2:0] wen,
                                 input logic [2:0][1:0] bank, input logic [2:0][3:0] addr,
                                 input logic [2:0][7:0] wdata);
        @(posedge clk);
        #1;
        req      = r;
        reqWen   = wen;
        reqBank  = bank;
        reqAddr  = addr;
        reqWdata = wdata;
        stWr     = '0;
        @(negedge clk);
    endtask

    task automatic applyState(input logic [2:0] wr, input logic [2:0][1:0] idx,
                              input bank_state_t [2:0] wd);
        @(posedge clk);
        #1;
        req     = '0;
        stWr    = wr;
        stIdx   = idx;
        stWdata = wd;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus('0, '0, '0, '0, '0);
    endtask

    // Scoreboard: pops on every read return, pushes on every granted read.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (rdataVld[p]) begin
                    if (expQ.size() == 0) begin
                        checkOutput("spuriousVld", 32'd1, 32'd0);
                    end else begin
                        expEntry_t e;
                        e = expQ.pop_front();
                        checkOutput("rdPort", 32'(p), 32'(e.port));
                        checkOutput("rdData", 32'(rdata[p]), 32'(e.data));
                        checkOutput("rdLatency", 32'(cycleCnt - e.cyc), 32'd2);
                    end
                end
            end
            for (int p = 0; p < 3; p++) begin
                if (gnt[p] && req[p]) begin
                    if (reqWen[p]) begin
                        modelMem[reqBank[p]][reqAddr[p]] = reqWdata[p];
                    end else begin
                        expQ.push_back('{port: p, data: modelMem[reqBank[p]][reqAddr[p]], cyc: cycleCnt});
                    end
                end
            end
        end
    end

    initial begin
        bank_state_t [2:0] sw;
        bank_state_t       rstState;
        bank_state_t       p1State;

        passCount   = 0;
        totalChecks = 0;
        cycleCnt    = 0;
        rst         = 1'b0;
        req         = '0;
        reqWen      = '0;
        reqBank     = '0;
        reqAddr     = '0;
        reqWdata    = '0;
        stWr        = '0;
        stIdx       = '0;
        stWdata     = '0;
        rstState    = '{status: BANK_IDLE, count: '0, head: '0};
        p1State     = '{status: BANK_FILL, count: 5'd5, head: 4'd3};

        #2 rst = 1'b1;
        @(negedge clk);
        req = 3'b111;
        @(negedge clk);
        checkOutput("gntInReset", 32'(gnt), 32'd0);
        checkOutput("vldReset", 32'(rdataVld), 32'd0);
        checkOutput("rdataReset", 32'(rdata), 32'd0);
        req = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        stIdx = {2'd2, 2'd1, 2'd0};
        @(negedge clk);
        for (int p = 0; p < 3; p++) checkOutput("stateReset", 32'(stRdata[p]), 32'(rstState));
        stIdx = {2'd3, 2'd3, 2'd3};
        @(negedge clk);
        checkOutput("stateReset3", 32'(stRdata[0]), 32'(rstState));

        // All ports hammer bank 1 with writes: expect 0,1,2,0,1,2.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'b111, 3'b111, {2'd1, 2'd1, 2'd1}, {4'd2, 4'd1, 4'd0},
                          {8'h12, 8'h11, 8'h10});
            checkOutput("contention", 32'(gnt), 32'(3'b001 << (i % 3)));
        end

        applyStimulus(3'b111, 3'b111, {2'd2, 2'd1, 2'd0}, {4'd1, 4'd1, 4'd1},
                      {8'h42, 8'h31, 8'h20});
        checkOutput("parWrite", 32'(gnt), 32'h7);
        applyStimulus(3'b111, 3'b000, {2'd2, 2'd1, 2'd0}, {4'd1, 4'd1, 4'd1}, '0);
        checkOutput("parRead", 32'(gnt), 32'h7);
        idleCycle();
        checkOutput("parVldT1", 32'(rdataVld), 32'h0);
        idleCycle();
        checkOutput("parVldT2", 32'(rdataVld), 32'h7);
        checkOutput("parData", 32'(rdata), 32'h423120);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b001, 3'b000, {2'd0, 2'd0, 2'd1}, {4'd0, 4'd0, 4'(i)}, '0);
            checkOutput("b2bGnt", 32'(gnt), 32'h1);
        end
        idleCycle();
        idleCycle();

        applyStimulus(3'b001, 3'b001, {2'd0, 2'd0, 2'd3}, {4'd0, 4'd0, 4'd7}, {8'h0, 8'h0, 8'hA5});
        checkOutput("wrGnt", 32'(gnt), 32'h1);
        applyStimulus(3'b100, 3'b000, {2'd3, 2'd0, 2'd0}, {4'd7, 4'd0, 4'd0}, '0);
        checkOutput("rdGnt", 32'(gnt), 32'h4);
        idleCycle();
        idleCycle();
        checkOutput("wrRdVld", 32'(rdataVld), 32'h4);
        checkOutput("wrRdData", 32'(rdata[2]), 32'hA5);
        idleCycle();
        checkOutput("holdVld", 32'(rdataVld), 32'h0);
        checkOutput("holdData", 32'(rdata[2]), 32'hA5);

        sw[0] = rstState;
        sw[1] = p1State;
        sw[2] = '{status: BANK_DRAIN, count: 5'd9, head: 4'd8};
        applyState(3'b110, {2'd0, 2'd0, 2'd0}, sw);
        checkOutput("stateNoBypass", 32'(stRdata[1]), 32'(rstState));
        idleCycle();
        checkOutput("stateCollision", 32'(stRdata[0]), 32'(p1State));

        applyStimulus(3'b001, 3'b000, {2'd0, 2'd0, 2'd3}, {4'd0, 4'd0, 4'd7}, '0);
        checkOutput("preRstGnt", 32'(gnt), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        req = 3'b111;
        @(negedge clk);
        checkOutput("rstGnt", 32'(gnt), 32'h0);
        checkOutput("rstVldT1", 32'(rdataVld), 32'h0);
        @(negedge clk);
        checkOutput("rstVldT2", 32'(rdataVld), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        req = '0;
        @(negedge clk);
        checkOutput("postRstVld", 32'(rdataVld), 32'h0);
        checkOutput("postRstState", 32'(stRdata[0]), 32'(rstState));
        applyStimulus(3'b111, 3'b000, {2'd2, 2'd2, 2'd2}, {4'd1, 4'd1, 4'd1}, '0);
        checkOutput("postRstWinner", 32'(gnt), 32'h1);
        idleCycle();
        idleCycle();
        idleCycle();
        checkOutput("drain", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule
